// File: rtl/gpio_cfg_serializer.sv
// gpio_cfg_serializer: fabric-side transmitter for the GPIO serial configuration bus and its strobes
module gpio_cfg_serializer #(
   parameter int DATA_W  = 256,
   parameter int CLK_DIV = 4,
   parameter int STRB_W  = 8
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [7:0]        cmd_target,
   input  logic [8:0]        cmd_len,
   input  logic [DATA_W-1:0] cmd_data,
   output logic [8:0]        gpio_out,
   output logic              busy,
   output logic              done,
   output logic              err
);
   localparam int MX = CLK_DIV > STRB_W ? CLK_DIV : STRB_W;
   localparam int CW = MX > 1 ? $clog2(MX) : 1;
   localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] STRB_LAST = CW'(STRB_W - 1);
   typedef enum logic [2:0] {IDLE, LOW, HIGH, STRB, DONE, ERR} state_t;
   state_t st, ns;
   logic [CW-1:0] div_q, div_n;
   logic [BW-1:0] bit_q, bit_n;
   logic [3:0] tgt_q, tgt_n;
   logic [DATA_W-1:0] data_q, data_n;
   logic [8:0] gpio_n;
   logic accept, is_strb, is_ser, bad, sd_n;
   assign accept = cmd_valid & cmd_ready;
   assign is_strb = cmd_target == 8'd5 || cmd_target == 8'd6;
   assign is_ser = cmd_target != 8'd0 && cmd_target <= 8'd8 && !is_strb;
   assign bad = !(is_strb || (is_ser && cmd_len != 9'd0 && int'(cmd_len) <= DATA_W));
   always_comb begin
      ns = st;
      div_n = div_q;
      bit_n = bit_q;
      tgt_n = tgt_q;
      data_n = data_q;
      case (st)
         IDLE: if (accept) begin
            tgt_n = cmd_target[3:0];
            data_n = cmd_data;
            bit_n = BW'(cmd_len - 9'd1);
            div_n = '0;
            ns = bad ? ERR : is_strb ? STRB : LOW;
         end
         LOW: begin
            div_n = div_q == DIV_LAST ? '0 : div_q + 1'b1;
            ns = div_q == DIV_LAST ? HIGH : LOW;
         end
         HIGH: begin
            div_n = div_q == DIV_LAST ? '0 : div_q + 1'b1;
            bit_n = div_q == DIV_LAST && bit_q != '0 ? bit_q - 1'b1 : bit_q;
            ns = div_q != DIV_LAST ? HIGH : bit_q != '0 ? LOW : DONE;
         end
         STRB: begin
            div_n = div_q == STRB_LAST ? '0 : div_q + 1'b1;
            ns = div_q == STRB_LAST ? DONE : STRB;
         end
         default: ns = IDLE;
      endcase
      // sdata only moves when the bit index does, which happens solely on entry to LOW
      sd_n = (ns == LOW || ns == HIGH) && data_n[bit_n];
      gpio_n = (9'(ns == HIGH || ns == STRB) << tgt_n) | 9'(sd_n);
   end
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         st <= IDLE;
         div_q <= '0;
         bit_q <= '0;
         tgt_q <= '0;
         data_q <= '0;
         cmd_ready <= 1'b0;
         gpio_out <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         err <= 1'b0;
      end else begin
         st <= ns;
         div_q <= div_n;
         bit_q <= bit_n;
         tgt_q <= tgt_n;
         data_q <= data_n;
         cmd_ready <= ns == IDLE;
         gpio_out <= gpio_n;
         busy <= ns inside {LOW, HIGH, STRB, DONE};
         done <= ns == DONE;
         err <= ns == ERR;
      end
   end
endmodule

// File: tb/tb_gpio_cfg_serializer.sv
// tb_gpio_cfg_serializer: directed commands with a queued scoreboard checked by a bus monitor
module tb_gpio_cfg_serializer;
   localparam int DW = 256, CD = 2, SW = 8;
   logic clk = 1'b0, rstn = 1'b0, cmd_valid = 1'b0;
   logic cmd_ready, busy, done, err;
   logic [7:0] cmd_target = '0;
   logic [8:0] cmd_len = '0;
   logic [DW-1:0] cmd_data = '0;
   logic [8:0] gpio_out;
   typedef struct {
      bit kind;
      int cyc;
      int tgt;
      int edges;
      int hi;
      int sdhi;
      logic [DW-1:0] val;
   } exp_t;
   exp_t q[$];
   int cyc = 0, n_chk = 0, n_pass = 0, acc = 0;
   int edges[9], hi[9], run[9];
   int sdhi = 0, sdv = 0, phv = 0;
   logic [DW-1:0] shreg = '0;
   logic [8:0] prev = '0;

   gpio_cfg_serializer #(.DATA_W(DW), .CLK_DIV(CD), .STRB_W(SW)) dut (
      .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_target(cmd_target), .cmd_len(cmd_len), .cmd_data(cmd_data),
      .gpio_out(gpio_out), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;
   initial forever @(posedge clk) cyc++;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic chkv(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [DW-1:0] mask(input int len);
      return len >= DW ? '1 : (DW'(1) << len) - DW'(1);
   endfunction

   function automatic void clear();
      for (int i = 0; i < 9; i++) begin
         edges[i] = 0;
         hi[i] = 0;
         run[i] = 0;
      end
      sdhi = 0;
      sdv = 0;
      phv = 0;
      shreg = '0;
   endfunction

   function automatic void push_exp(input int tgt, input int len, input logic [DW-1:0] data, input int a);
      exp_t e;
      bit strb, bad;
      strb = tgt == 5 || tgt == 6;
      bad = tgt == 0 || tgt > 8 || (!strb && (len == 0 || len > DW));
      e.kind = !bad;
      e.tgt = tgt;
      e.cyc = bad ? a : strb ? a + SW : a + 2 * len * CD;
      e.edges = bad ? 0 : strb ? 1 : len;
      e.hi = bad ? 0 : strb ? SW : len * CD;
      e.val = (bad || strb) ? '0 : data & mask(len);
      e.sdhi = $countones(e.val) * 2 * CD;
      q.push_back(e);
   endfunction

   task automatic send(input int tgt, input int len, input logic [DW-1:0] data, input bit p);
      int w = 0;
      @(negedge clk);
      while (!cmd_ready && w < 5000) begin
         @(negedge clk);
         w++;
      end
      chk("ready_wait", int'(cmd_ready), 1);
      cmd_valid = 1'b1;
      cmd_target = 8'(tgt);
      cmd_len = 9'(len);
      cmd_data = data;
      @(posedge clk);
      #1;
      acc = cyc;
      cmd_valid = 1'b0;
      if (p) push_exp(tgt, len, data, acc);
   endtask

   task automatic check_end();
      exp_t e;
      int et = 0, ht = 0;
      for (int i = 1; i < 9; i++) begin
         et += edges[i];
         ht += hi[i];
      end
      if (q.size() == 0) begin
         n_chk++;
         $display("FAIL unexpected_end: done=%0b err=%0b with no command pending", done, err);
      end else begin
         e = q.pop_front();
         chk("end_kind", int'({done, err}), e.kind ? 2 : 1);
         chk("end_cycle", cyc, e.cyc);
         chk("end_gpio_idle", int'(gpio_out), 0);
         chk("end_ready_low", int'(cmd_ready), 0);
         if (e.kind) begin
            chk("edges_target", edges[e.tgt], e.edges);
            chk("edges_others", et - edges[e.tgt], 0);
            chk("high_cycles", hi[e.tgt], e.hi);
            chk("busy_at_done", int'(busy), 1);
         end else begin
            chk("err_no_edges", et, 0);
            chk("err_no_high", ht, 0);
         end
         chkv("shift_reg", shreg, e.val);
         chk("sdata_high_cycles", sdhi, e.sdhi);
         chk("sdata_stable_clk_high", sdv, 0);
         chk("clk_phase_width", phv, 0);
      end
      clear();
   endtask

   initial begin
      clear();
      forever begin
         @(negedge clk);
         if (!rstn) begin
            clear();
            prev = '0;
         end else begin
            for (int i = 1; i < 9; i++) begin
               if (gpio_out[i] && !prev[i]) begin
                  edges[i]++;
                  shreg = {shreg[DW-2:0], gpio_out[0]};
               end
               if (gpio_out[i]) begin
                  hi[i]++;
                  run[i]++;
               end
               if (!gpio_out[i] && prev[i]) begin
                  if (i != 5 && i != 6 && run[i] != CD) phv++;
                  run[i] = 0;
               end
            end
            if ((gpio_out[8:1] & prev[8:1] & 8'b1100_1111) != 8'd0 && gpio_out[0] != prev[0]) sdv++;
            if (gpio_out[0]) sdhi++;
            if (done || err) check_end();
            prev = gpio_out;
         end
      end
   end

   initial begin
      int w, n, a1;
      bit r;
      int inv_t[4] = '{0, 9, 1, 1};
      int inv_l[4] = '{4, 4, 0, 257};
      repeat (3) @(negedge clk);
      chk("rst_ready", int'(cmd_ready), 0);
      chk("rst_outputs", int'({busy, done, err, gpio_out}), 0);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_after_release", int'(cmd_ready), 1);
      chk("gpio_after_release", int'(gpio_out), 0);
      send(2, 16, DW'(16'h0004), 1'b1);
      send(3, 256, {32{8'hA5}}, 1'b1);
      send(6, 0, '0, 1'b1);
      a1 = acc;
      cmd_valid = 1'b1;
      cmd_target = 8'd5;
      cmd_len = 9'd0;
      w = 0;
      do begin
         @(negedge clk);
         r = cmd_ready;
         @(posedge clk);
         #1;
         w++;
      end while (!r && w < 100);
      acc = cyc;
      cmd_valid = 1'b0;
      push_exp(5, 0, '0, acc);
      chk("b2b_accept_cycle", acc, a1 + SW + 2);
      for (int k = 0; k < 4; k++) begin
         send(inv_t[k], inv_l[k], '1, 1'b1);
         @(negedge clk);
         chk("inv_ready_low", int'(cmd_ready), 0);
         chk("inv_gpio_quiet", int'(gpio_out), 0);
         @(negedge clk);
         chk("inv_ready_back", int'(cmd_ready), 1);
      end
      send(8, 9, DW'(9'h155), 1'b1);
      send(7, 1, DW'(1), 1'b1);
      send(1, 32, DW'(32'hDEADBEEF), 1'b0);
      w = 0;
      while (edges[1] < 5 && w < 1000) begin
         @(negedge clk);
         w++;
      end
      #1;
      chk("abort_at_bit5", edges[1], 5);
      chk("abort_clk_high", int'(gpio_out[1]), 1);
      rstn = 1'b0;
      #1;
      chk("abort_async_clear", int'({cmd_ready, busy, done, err, gpio_out}), 0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      n = 0;
      repeat (150) begin
         @(negedge clk);
         if (done || err) n++;
      end
      chk("abort_no_end", n, 0);
      send(4, 4, DW'(4'hB), 1'b1);
      w = 0;
      while (q.size() != 0 && w < 5000) begin
         @(negedge clk);
         w++;
      end
      chk("queue_drained", q.size(), 0);
      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
